// File: rtl/instr_dispatcher.sv
// instr_dispatcher
//   Buffers instructions issued by the controller and routes each one by
//   opcode. Memory-class ops go to the memory unit. SENDITERS goes to the
//   frame-buffer writer once memory is idle. Controller-local ops retire
//   silently. END drains both units and then raises done_out until start_in.
//
// Ports
//   clk_in, rst_in                 clock, asynchronous active-low reset
//   instr_in, reg_{a,b,c}_in       instruction + operands from controller
//   instr_valid_in/instr_ready_out controller handshake
//   mem_instr_out, mem_reg_*_out   memory-unit request payload
//   mem_valid_out/mem_ready_in     memory-unit handshake, mem_busy_in = in flight
//   fb_addr_out                    SENDITERS target address (reg_a)
//   fb_valid_out/fb_ready_in       frame-buffer handshake, fb_busy_in = in flight
//   start_in, done_out             restart pulse / program finished and drained
//   mem_issued_out, fb_issued_out  wrapping transfer counters
module instr_dispatcher #(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned PRIVATE_REG_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned COUNT_WIDTH       = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [0:INSTRUCTION_WIDTH-1]   instr_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]   reg_a_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]   reg_b_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]   reg_c_in,
  input  logic                           instr_valid_in,
  output logic                           instr_ready_out,
  output logic [0:INSTRUCTION_WIDTH-1]   mem_instr_out,
  output logic [PRIVATE_REG_WIDTH-1:0]   mem_reg_a_out,
  output logic [PRIVATE_REG_WIDTH-1:0]   mem_reg_b_out,
  output logic [PRIVATE_REG_WIDTH-1:0]   mem_reg_c_out,
  output logic                           mem_valid_out,
  input  logic                           mem_ready_in,
  input  logic                           mem_busy_in,
  output logic [PRIVATE_REG_WIDTH-1:0]   fb_addr_out,
  output logic                           fb_valid_out,
  input  logic                           fb_ready_in,
  input  logic                           fb_busy_in,
  input  logic                           start_in,
  output logic                           done_out,
  output logic [COUNT_WIDTH-1:0]         mem_issued_out,
  output logic [COUNT_WIDTH-1:0]         fb_issued_out
);

  localparam int unsigned PRW = PRIVATE_REG_WIDTH;
  localparam int unsigned IW  = INSTRUCTION_WIDTH;
  localparam int unsigned EW  = IW + 3 * PRW;
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t r_state, w_next_state;

  logic [EW-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_fb_hold;
  logic [COUNT_WIDTH-1:0] r_mem_cnt, r_fb_cnt;

  logic [EW-1:0] w_head;
  logic [3:0]    w_op;
  logic          w_head_valid, w_run;
  logic          w_is_mem, w_is_fb, w_is_end, w_is_local;
  logic          w_mem_valid, w_fb_valid, w_mem_xfer, w_fb_xfer;
  logic          w_drained, w_ready, w_push, w_pop;

  // Head decode
  assign w_head       = r_fifo[r_rptr];
  assign w_op         = w_head[EW-1 -: 4];
  assign w_head_valid = (r_count != '0);
  assign w_run        = (r_state == ST_RUN);
  assign w_is_mem     = (w_op >= 4'h6) && (w_op <= 4'hD);
  assign w_is_fb      = (w_op == 4'hE);
  assign w_is_end     = (w_op == 4'h1);
  assign w_is_local   = !(w_is_mem || w_is_fb || w_is_end);

  // Dispatch only happens in RUN, so entries queued behind END stay put until restart.
  assign w_mem_valid = w_run && w_head_valid && w_is_mem;
  // Once offered, the frame-buffer request is held even if mem_busy_in rises again.
  assign w_fb_valid  = w_run && w_head_valid && w_is_fb && !w_mem_valid &&
                       (r_fb_hold || !mem_busy_in);
  assign w_mem_xfer  = w_mem_valid && mem_ready_in;
  assign w_fb_xfer   = w_fb_valid && fb_ready_in;
  assign w_drained   = (r_state == ST_DRAIN) && !mem_busy_in && !fb_busy_in;

  assign w_ready = rst_in && (r_count != FULL_CNT) && w_run;
  assign w_push  = instr_valid_in && w_ready;
  // In DRAIN the head is always the END that caused it; it retires on the drained edge.
  assign w_pop   = (w_run && w_head_valid && w_is_local) || w_mem_xfer || w_fb_xfer || w_drained;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= ST_RUN;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_RUN:   if (w_head_valid && w_is_end) w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_drained)                w_next_state = ST_DONE;
      ST_DONE:  if (start_in)                 w_next_state = ST_RUN;
      default:                                w_next_state = ST_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    instr_ready_out = w_ready;
    done_out        = (r_state == ST_DONE);
    mem_valid_out   = w_mem_valid;
    fb_valid_out    = w_fb_valid;
    mem_instr_out   = '0;
    mem_reg_a_out   = '0;
    mem_reg_b_out   = '0;
    mem_reg_c_out   = '0;
    fb_addr_out     = '0;
    if (w_mem_valid) begin
      mem_instr_out = w_head[EW-1 -: IW];
      mem_reg_a_out = w_head[3*PRW-1 -: PRW];
      mem_reg_b_out = w_head[2*PRW-1 -: PRW];
      mem_reg_c_out = w_head[PRW-1:0];
    end
    if (w_fb_valid) fb_addr_out = w_head[3*PRW-1 -: PRW];
    mem_issued_out = r_mem_cnt;
    fb_issued_out  = r_fb_cnt;
  end

  // FIFO storage needs no reset: nothing reads it while the count is zero.
  always_ff @(posedge clk_in) begin
    if (w_push) r_fifo[r_wptr] <= {instr_in, reg_a_in, reg_b_in, reg_c_in};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_fb_hold <= 1'b0;
      r_mem_cnt <= '0;
      r_fb_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_fb_xfer)       r_fb_hold <= 1'b0;
      else if (w_fb_valid) r_fb_hold <= 1'b1;
      if (w_mem_xfer) r_mem_cnt <= r_mem_cnt + 1'b1;
      if (w_fb_xfer)  r_fb_cnt  <= r_fb_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_dispatcher.sv
module tb_instr_dispatcher;
  localparam int IW  = 32;
  localparam int PRW = 16;
  localparam int CW  = 16;
  typedef logic [IW+3*PRW-1:0] ent_t;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b0;
  logic [0:IW-1]   instr_in = '0;
  logic [PRW-1:0]  reg_a_in = '0, reg_b_in = '0, reg_c_in = '0;
  logic            instr_valid_in = 1'b0;
  logic            instr_ready_out;
  logic [0:IW-1]   mem_instr_out;
  logic [PRW-1:0]  mem_reg_a_out, mem_reg_b_out, mem_reg_c_out;
  logic            mem_valid_out;
  logic            mem_ready_in = 1'b0, mem_busy_in = 1'b0;
  logic [PRW-1:0]  fb_addr_out;
  logic            fb_valid_out;
  logic            fb_ready_in = 1'b0, fb_busy_in = 1'b0;
  logic            start_in = 1'b0;
  logic            done_out;
  logic [CW-1:0]   mem_issued_out, fb_issued_out;

  always #5 clk_in = ~clk_in;

  instr_dispatcher #(
    .INSTRUCTION_WIDTH(IW), .PRIVATE_REG_WIDTH(PRW), .FIFO_DEPTH(8), .COUNT_WIDTH(CW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .instr_in(instr_in), .reg_a_in(reg_a_in), .reg_b_in(reg_b_in), .reg_c_in(reg_c_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .mem_instr_out(mem_instr_out), .mem_reg_a_out(mem_reg_a_out),
    .mem_reg_b_out(mem_reg_b_out), .mem_reg_c_out(mem_reg_c_out),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in), .mem_busy_in(mem_busy_in),
    .fb_addr_out(fb_addr_out), .fb_valid_out(fb_valid_out),
    .fb_ready_in(fb_ready_in), .fb_busy_in(fb_busy_in),
    .start_in(start_in), .done_out(done_out),
    .mem_issued_out(mem_issued_out), .fb_issued_out(fb_issued_out)
  );

  ent_t           mem_q[$];
  logic [PRW-1:0] fb_q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [CW-1:0]  exp_mem  = '0;
  logic [CW-1:0]  exp_fb   = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [27:0] payload);
    return {op, payload};
  endfunction

  // Drive one instruction and hold it until accepted; record the expected output.
  task automatic push(input logic [IW-1:0] ins, input logic [PRW-1:0] a,
                      input logic [PRW-1:0] b, input logic [PRW-1:0] c);
    logic [3:0] op;
    bit ok;
    op = ins[IW-1 -: 4];
    ok = 1'b0;
    @(negedge clk_in);
    instr_in = ins; reg_a_in = a; reg_b_in = b; reg_c_in = c;
    instr_valid_in = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (instr_ready_out === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk_in);
    end
    if (ok) begin
      if (op >= 4'h6 && op <= 4'hD) begin mem_q.push_back({ins, a, b, c}); exp_mem++; end
      else if (op == 4'hE) begin fb_q.push_back(a); exp_fb++; end
      @(posedge clk_in);
      #1;
    end else begin
      chk("push_accept", instr_ready_out, 1'b1);
    end
    instr_valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in); #3;
      if (mem_q.size() == 0 && fb_q.size() == 0) break;
    end
    chk("scoreboard_drained", 128'(mem_q.size() + fb_q.size()), 0);
    @(negedge clk_in); #2;
    chk("mem_issued", mem_issued_out, exp_mem);
    chk("fb_issued", fb_issued_out, exp_fb);
  endtask

  // Output monitor: transfers happen at the next rising edge when valid & ready.
  always begin
    ent_t e;
    logic [PRW-1:0] fa;
    @(negedge clk_in); #2;
    if (rst_in === 1'b1) begin
      if (mem_valid_out || fb_valid_out)
        chk("one_valid", mem_valid_out & fb_valid_out, 1'b0);
      if (mem_valid_out && mem_ready_in) begin
        e = (mem_q.size() > 0) ? mem_q.pop_front() : 'x;
        chk("mem_data", {mem_instr_out, mem_reg_a_out, mem_reg_b_out, mem_reg_c_out}, e);
      end
      if (fb_valid_out && fb_ready_in) begin
        fa = (fb_q.size() > 0) ? fb_q.pop_front() : 'x;
        chk("fb_addr", fb_addr_out, fa);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk_in);
    #2;
    chk("rst_ready", instr_ready_out, 1'b0);
    chk("rst_mem_valid", mem_valid_out, 1'b0);
    chk("rst_fb_valid", fb_valid_out, 1'b0);
    chk("rst_done", done_out, 1'b0);
    chk("rst_counters", {mem_issued_out, fb_issued_out}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    #2;
    chk("post_rst_ready", instr_ready_out, 1'b1);

    // 1: local op dropped, memory ops in order
    mem_ready_in = 1'b1;
    fb_ready_in  = 1'b1;
    push(mk(4'h3, 28'h0000111), 16'h1111, 16'h2222, 16'h3333);
    push(mk(4'h6, 28'h0000AAA), 16'hA001, 16'hA002, 16'hA003);
    push(mk(4'h7, 28'h0000BBB), 16'hB001, 16'hB002, 16'hB003);
    push(mk(4'h8, 28'h0000CCC), 16'hC001, 16'hC002, 16'hC003);
    drain();
    chk("t1_mem_issued", mem_issued_out, 16'd3);
    chk("t1_fb_issued", fb_issued_out, 16'd0);

    // 2: backpressure fills the FIFO
    mem_ready_in = 1'b0;
    for (int i = 0; i < 8; i++)
      push(mk(4'h6 + 4'(i % 8), 28'(32'h100 + i)), 16'(i), 16'(i + 1), 16'(i + 2));
    @(negedge clk_in);
    instr_in = mk(4'h9, 28'h0000999); reg_a_in = 16'h0909; reg_b_in = 16'h0; reg_c_in = 16'h0;
    instr_valid_in = 1'b1;
    #2;
    chk("t2_full_ready", instr_ready_out, 1'b0);
    @(negedge clk_in); #2;
    chk("t2_full_ready2", instr_ready_out, 1'b0);
    chk("t2_head_hold", mem_instr_out, mk(4'h6, 28'h100));
    @(negedge clk_in);
    mem_ready_in = 1'b1;
    push(mk(4'h9, 28'h0000999), 16'h0909, 16'h0, 16'h0);
    drain();

    // 3: SENDITERS waits for memory idle
    mem_busy_in = 1'b1;
    push(mk(4'hD, 28'h00000D0), 16'hD0D0, 16'h0, 16'h0);
    push(mk(4'hE, 28'h00000E0), 16'h0123, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in); #2;
      chk("t3_fb_blocked", fb_valid_out, 1'b0);
    end
    @(negedge clk_in);
    mem_busy_in = 1'b0;
    #2;
    chk("t3_fb_valid", fb_valid_out, 1'b1);
    chk("t3_fb_addr", fb_addr_out, 16'h0123);
    @(negedge clk_in); #2;
    chk("t3_fb_issued", fb_issued_out, 16'd1);

    // 4: END drains, entry behind END stays buffered, start resumes
    fb_busy_in = 1'b1;
    push(mk(4'h1, 28'h0), 16'h0, 16'h0, 16'h0);
    push(mk(4'hA, 28'h00000AA), 16'hAAAA, 16'h5555, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      start_in = (i == 1);
      #2;
      chk("t4_drain_done", done_out, 1'b0);
      chk("t4_drain_ready", instr_ready_out, 1'b0);
    end
    @(negedge clk_in);
    start_in   = 1'b0;
    fb_busy_in = 1'b0;
    #2;
    chk("t4_done_not_yet", done_out, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in); #2;
      chk("t4_done", done_out, 1'b1);
      chk("t4_done_ready", instr_ready_out, 1'b0);
      chk("t4_held_mem", mem_valid_out, 1'b0);
    end
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    #2;
    chk("t4_restart_done", done_out, 1'b0);
    chk("t4_restart_ready", instr_ready_out, 1'b1);
    drain();

    // 5: asynchronous reset mid-transfer
    mem_ready_in = 1'b0;
    push(mk(4'hB, 28'h00000BB), 16'hBEEF, 16'h0, 16'h0);
    @(negedge clk_in); #2;
    chk("t5_valid_before", mem_valid_out, 1'b1);
    #1 rst_in = 1'b0;
    #1;
    chk("t5_valid_async", mem_valid_out, 1'b0);
    chk("t5_data_zero", mem_instr_out, 0);
    chk("t5_ready_rst", instr_ready_out, 1'b0);
    mem_q.delete();
    fb_q.delete();
    exp_mem = '0;
    exp_fb  = '0;
    @(negedge clk_in);
    rst_in = 1'b1;
    #2;
    chk("t5_counters", {mem_issued_out, fb_issued_out}, 0);
    chk("t5_fifo_empty", mem_valid_out, 1'b0);
    chk("t5_ready", instr_ready_out, 1'b1);

    // 6: counter wrap
    mem_ready_in = 1'b1;
    for (int i = 0; i < 65535; i++)
      push(mk(4'h6 + 4'(i % 8), 28'(i)), 16'(i), 16'(~i), 16'(i * 3));
    drain();
    chk("t6_pre_wrap", mem_issued_out, 16'hFFFF);
    push(mk(4'hC, 28'h0C0FFEE), 16'h7777, 16'h8888, 16'h9999);
    drain();
    chk("t6_wrapped", mem_issued_out, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
